// File: rtl/sink_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sink_seq_pkg
//  Brief   : Shared types and sizing helpers for the sink run sequencer.
//            Optional index byte controlled by macro SINK_SEQ_INDEX_EN.
//  Revision: 1.0 - initial release
// ============================================================================
package sink_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SEND    = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_t;

    function automatic int bytes_per_vec(input int num_out);
        return (num_out + 7) / 8;
    endfunction

    function automatic int padded_width(input int num_out);
        return bytes_per_vec(num_out) * 8;
    endfunction

    function automatic int byte_cnt_width(input int num_out);
        return $clog2(bytes_per_vec(num_out) + 1);
    endfunction

`ifdef SINK_SEQ_INDEX_EN
    localparam int c_index_bytes = 1;
`else
    localparam int c_index_bytes = 0;
`endif

endpackage
`default_nettype wire

// File: rtl/vec_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module  : vec_byte_packer
//  Brief   : Bit-reverses and left-justifies a network vector, then shifts it
//            out MSB byte first. Index byte prepended under SINK_SEQ_INDEX_EN.
//  Revision: 1.0 - initial release
// ============================================================================
module vec_byte_packer
    import sink_seq_pkg::*;
#(
    parameter int NUM_OUT = 8
) (
    input  logic               clk,
    input  logic               arstn,
    input  logic               load,
    input  logic               shift,
    input  logic [NUM_OUT-1:0] vec_in,
`ifdef SINK_SEQ_INDEX_EN
    input  logic [7:0]         idx_in,
`endif
    output logic [7:0]         byte_out,
    output logic               last_byte
);

    localparam int c_pad_w     = padded_width(NUM_OUT);
    localparam int c_sr_w      = c_pad_w + 8 * c_index_bytes;
    localparam int c_num_bytes = bytes_per_vec(NUM_OUT) + c_index_bytes;
    localparam int c_cnt_w     = byte_cnt_width(NUM_OUT);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_num_bytes - 1);

    logic [c_pad_w-1:0] w_padded;
    logic [c_sr_w-1:0]  w_load_val;
    logic [c_sr_w-1:0]  r_sr;
    logic [c_cnt_w-1:0] r_byte_cnt;

    // Output 0 lands in the MSB; low pad bits stay zero.
    always_comb begin
        w_padded = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            w_padded[c_pad_w-1-i] = vec_in[i];
        end
    end

`ifdef SINK_SEQ_INDEX_EN
    assign w_load_val = {idx_in, w_padded};
`else
    assign w_load_val = w_padded;
`endif

    // The counter may wrap after the final byte; the next load clears it.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_sr       <= '0;
            r_byte_cnt <= '0;
        end else if (load) begin
            r_sr       <= w_load_val;
            r_byte_cnt <= '0;
        end else if (shift) begin
            r_sr       <= r_sr << 8;
            r_byte_cnt <= r_byte_cnt + c_cnt_w'(1);
        end
    end

    assign byte_out  = r_sr[c_sr_w-1 -: 8];
    assign last_byte = (r_byte_cnt == c_last_cnt);

endmodule
`default_nettype wire

// File: rtl/sink_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : sink_run_sequencer
//  Brief   : Collects N network output vectors per host command and streams
//            them as bytes. Macro SINK_SEQ_INDEX_EN adds a per-vector index byte.
//  Revision: 1.0 - initial release
// ============================================================================
module sink_run_sequencer
    import sink_seq_pkg::*;
#(
    parameter int NUM_OUT   = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CNT_WIDTH-1:0] cmd_runs,
    input  logic                 net_valid,
    output logic                 net_ready,
    input  logic [NUM_OUT-1:0]   net_out,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic                 done
);

    seq_state_t           r_state;
    seq_state_t           w_state_nxt;
    logic [CNT_WIDTH-1:0] r_remaining;
    logic                 w_cmd_xfer;
    logic                 w_net_xfer;
    logic                 w_tx_xfer;
    logic                 w_last_byte;
    logic                 w_vec_end;

    // Handshake outputs decode straight from the state register.
    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign net_ready = (r_state == ST_CAPTURE);
    assign tx_valid  = (r_state == ST_SEND);
    assign done      = (r_state == ST_DONE);

    assign w_cmd_xfer = cmd_valid & cmd_ready;
    assign w_net_xfer = net_valid & net_ready;
    assign w_tx_xfer  = tx_valid & tx_ready;
    assign w_vec_end  = w_tx_xfer & w_last_byte;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_xfer) begin
                    w_state_nxt = (cmd_runs == '0) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_net_xfer) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_vec_end) begin
                    w_state_nxt = (r_remaining == CNT_WIDTH'(1)) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Completion is tested on the pre-decrement value, so N = 2^CNT_WIDTH-1 never wraps.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_remaining <= '0;
        end else if (w_cmd_xfer) begin
            r_remaining <= cmd_runs;
        end else if (w_vec_end) begin
            r_remaining <= r_remaining - CNT_WIDTH'(1);
        end
    end

`ifdef SINK_SEQ_INDEX_EN
    logic [7:0] r_vec_idx;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_vec_idx <= '0;
        end else if (w_cmd_xfer) begin
            r_vec_idx <= '0;
        end else if (w_vec_end) begin
            r_vec_idx <= r_vec_idx + 8'd1;
        end
    end
`endif

    vec_byte_packer #(
        .NUM_OUT (NUM_OUT)
    ) u_packer (
        .clk       (clk),
        .arstn     (arstn),
        .load      (w_net_xfer),
        .shift     (w_tx_xfer),
        .vec_in    (net_out),
`ifdef SINK_SEQ_INDEX_EN
        .idx_in    (r_vec_idx),
`endif
        .byte_out  (tx_data),
        .last_byte (w_last_byte)
    );

endmodule
`default_nettype wire

// File: tb/tb_sink_run_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_sink_run_sequencer
//  Brief   : Randomized bench with a byte-queue scoreboard for the sequencer.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_sink_run_sequencer;

    localparam int NUM_OUT   = 12;
    localparam int CNT_WIDTH = 16;
    localparam int BPV       = (NUM_OUT + 7) / 8;
`ifdef SINK_SEQ_INDEX_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 arstn;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CNT_WIDTH-1:0] cmd_runs;
    logic                 net_valid;
    logic                 net_ready;
    logic [NUM_OUT-1:0]   net_out;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [7:0]           tx_data;
    logic                 busy;
    logic                 done;

    always #5 clk = ~clk;

    sink_run_sequencer #(
        .NUM_OUT   (NUM_OUT),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_dut (
        .clk       (clk),
        .arstn     (arstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_runs  (cmd_runs),
        .net_valid (net_valid),
        .net_ready (net_ready),
        .net_out   (net_out),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int                 n;
        int                 p_tx;
        int                 p_net;
        bit                 rst_mid;
        bit                 use_fixed;
        logic [NUM_OUT-1:0] fixed;
    } cmd_t;

    cmd_t       cmds[$];
    logic [7:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void add_cmd(input int n, input int p_tx, input int p_net,
                                    input bit rst_mid, input bit use_fixed,
                                    input logic [NUM_OUT-1:0] fixed);
        cmd_t c;
        c.n = n; c.p_tx = p_tx; c.p_net = p_net;
        c.rst_mid = rst_mid; c.use_fixed = use_fixed; c.fixed = fixed;
        cmds.push_back(c);
    endfunction

    // Reference: output i goes to bit (BPV*8-1-i) of a zero-padded word, bytes MSB first.
    function automatic void push_vector(input logic [NUM_OUT-1:0] v, input int idx);
        logic [BPV*8-1:0] word;
        word = '0;
        for (int i = 0; i < NUM_OUT; i++) word[BPV*8-1-i] = v[i];
        if (IDX_EN) exp_q.push_back(8'(idx % 256));
        for (int b = 0; b < BPV; b++) exp_q.push_back(word[(BPV*8-1-8*b) -: 8]);
    endfunction

    initial begin
        int                 cmd_idx = 0;
        bit                 presented = 0;
        bit                 active = 0;
        bit                 exp_done = 0;
        bit                 rst_pending = 0;
        bit                 prev_stall = 0;
        bit                 finished = 0;
        logic [7:0]         prev_data = '0;
        logic [7:0]         exp_byte;
        int                 cur_n = 0, cur_ptx = 50, cur_pnet = 50, vecs = 0, bytes_sent = 0;
        bit                 cur_rst = 0, cur_use_fixed = 0;
        logic [NUM_OUT-1:0] cur_fixed = '0;
        int                 dones_seen = 0, dones_exp = 0;

        arstn = 1'b0; cmd_valid = 1'b0; cmd_runs = '0;
        net_valid = 1'b0; net_out = '0; tx_ready = 1'b0;

        add_cmd(1,   100, 100, 0, 1, 12'hABC);
        add_cmd(0,   50,  50,  0, 0, '0);
        add_cmd(3,   50,  60,  0, 0, '0);
        add_cmd(0,   100, 100, 0, 0, '0);
        add_cmd(2,   100, 100, 1, 0, '0);
        add_cmd(1,   70,  80,  0, 0, '0);
        for (int k = 0; k < 6; k++) add_cmd(int'($urandom_range(1, 6)), int'($urandom_range(20, 100)),
                                            int'($urandom_range(20, 100)), 0, 0, '0);
        add_cmd(257, 100, 100, 0, 1, 12'hFFF);
        foreach (cmds[k]) if (!cmds[k].rst_mid) dones_exp++;

        repeat (2) @(negedge clk);
        check_val("reset_cmd_ready", cmd_ready, 1);
        check_val("reset_net_ready", net_ready, 0);
        check_val("reset_tx_valid",  tx_valid,  0);
        check_val("reset_tx_data",   tx_data,   0);
        check_val("reset_busy",      busy,      0);
        check_val("reset_done",      done,      0);
        arstn = 1'b1;

        for (int cyc = 0; cyc < 60000; cyc++) begin
            @(negedge clk);
            if (rst_pending) begin
                arstn = 1'b0; cmd_valid = 1'b0; net_valid = 1'b0; tx_ready = 1'b0;
                #1;
                check_val("async_rst_cmd_ready", cmd_ready, 1);
                check_val("async_rst_net_ready", net_ready, 0);
                check_val("async_rst_tx_valid",  tx_valid,  0);
                check_val("async_rst_tx_data",   tx_data,   0);
                check_val("async_rst_busy",      busy,      0);
                check_val("async_rst_done",      done,      0);
                exp_q.delete();
                active = 0; presented = 0; exp_done = 0; rst_pending = 0; prev_stall = 0;
                @(negedge clk);
                arstn = 1'b1;
            end

            // Observe outputs settled from the last rising edge.
            if (prev_stall) begin
                check_val("stall_tx_valid", tx_valid, 1);
                check_val("stall_tx_data",  tx_data,  prev_data);
            end
            check_val("net_tx_exclusive", net_ready & tx_valid, 0);
            check_val("cmd_ready", cmd_ready, !active);
            check_val("busy", busy, active);
            check_val("done", done, exp_done);
            if (done) dones_seen++;
            if (!active || vecs >= cur_n) check_val("net_ready_extra", net_ready, 0);
            if (exp_q.size() == 0) check_val("tx_valid_extra", tx_valid, 0);

            if (cmd_idx >= cmds.size() && !active && !presented) begin
                finished = 1;
                break;
            end
            if (exp_done) active = 0;
            exp_done = 0;

            // Drive inputs for the next edge.
            if (!presented) cmd_valid = 1'b0;
            if (!presented && cmd_idx < cmds.size() && $urandom_range(0, 1) == 1) begin
                presented = 1;
                cmd_valid = 1'b1;
                cmd_runs  = CNT_WIDTH'(cmds[cmd_idx].n);
            end
            net_valid = ($urandom_range(0, 99) < cur_pnet);
            net_out   = cur_use_fixed ? cur_fixed : NUM_OUT'($urandom);
            tx_ready  = ($urandom_range(0, 99) < cur_ptx);

            // Transfers that the next rising edge will complete.
            if (cmd_valid && cmd_ready) begin
                cur_n = cmds[cmd_idx].n; cur_ptx = cmds[cmd_idx].p_tx; cur_pnet = cmds[cmd_idx].p_net;
                cur_rst = cmds[cmd_idx].rst_mid; cur_use_fixed = cmds[cmd_idx].use_fixed;
                cur_fixed = cmds[cmd_idx].fixed;
                cmd_idx++; presented = 0; active = 1; vecs = 0; bytes_sent = 0;
                if (cur_n == 0) exp_done = 1;
            end
            if (net_valid && net_ready) begin
                push_vector(net_out, vecs);
                vecs++;
            end
            if (tx_valid && tx_ready && exp_q.size() > 0) begin
                exp_byte = exp_q.pop_front();
                check_val("tx_byte", tx_data, exp_byte);
                bytes_sent++;
                if (cur_rst && bytes_sent == 1) rst_pending = 1;
                else if (exp_q.size() == 0 && vecs == cur_n) exp_done = 1;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end

        check_val("run_complete", finished, 1);
        check_val("done_pulse_count", dones_seen, dones_exp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
